// File: rtl/avalon_pio_ex_pkg.sv
// Shared constants for the extended Avalon-MM PIO: register address map
// and edge-capture mode encodings.
package avalon_pio_ex_pkg;

  // Register word addresses
  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_INPUT   = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam logic [2:0] ADDR_PULSE   = 3'd6;
  localparam logic [2:0] ADDR_RSVD    = 3'd7;

  // Edge-capture modes
  localparam int EDGE_RISE = 32'sd0;
  localparam int EDGE_FALL = 32'sd1;
  localparam int EDGE_ANY  = 32'sd2;

endpackage

// File: rtl/avalon_pio_ex_in_sync.sv
// Input path for the PIO: multi-stage synchroniser for asynchronous
// in_port bits, one delay flop, and per-bit edge detection.
import avalon_pio_ex_pkg::*;

module pio_in_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_evt
);

  logic [WIDTH-1:0] sync_chain_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d_r;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;

  // Synchroniser chain plus one extra stage to compare against
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_chain_r[i] <= {WIDTH{1'b0}};
      end
      sync_d_r <= {WIDTH{1'b0}};
    end else begin
      sync_chain_r[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_chain_r[i] <= sync_chain_r[i-1];
      end
      sync_d_r <= sync_chain_r[SYNC_STAGES-1];
    end
  end

  assign sync_in = sync_chain_r[SYNC_STAGES-1];
  assign rise_s  = sync_in & ~sync_d_r;
  assign fall_s  = ~sync_in & sync_d_r;

  // Select which transitions count as a capture event
  always_comb begin
    edge_evt = {WIDTH{1'b0}};
    case (EDGE_TYPE)
      EDGE_RISE: edge_evt = rise_s;
      EDGE_FALL: edge_evt = fall_s;
      EDGE_ANY:  edge_evt = rise_s | fall_s;
      default:   edge_evt = rise_s | fall_s;
    endcase
  end

endmodule

// File: rtl/avalon_pio_ex.sv
// Parametrised Avalon-MM GPIO slave: output register with atomic set/clear,
// shared-timer pulse outputs, synchronised inputs with sticky edge capture
// and a maskable interrupt. Reads are combinational with zero wait states.
import avalon_pio_ex_pkg::*;

module avalon_pio_ex #(
  parameter int          WIDTH       = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
  parameter int          PULSE_LEN   = 4,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int CNT_W = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] RST_DATA = RESET_VALUE[WIDTH-1:0];

  logic             wr_s;
  logic [WIDTH-1:0] wd_s;
  logic             unused_wd_s;
  logic             pulse_wr_s;
  logic [WIDTH-1:0] sync_in_s;
  logic [WIDTH-1:0] edge_evt_s;

  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] irq_mask_r;
  logic [WIDTH-1:0] edge_cap_r;
  logic [WIDTH-1:0] pulse_bits_r;
  logic [CNT_W-1:0] pulse_cnt_r;

  assign wr_s        = chipselect & ~write_n;
  assign wd_s        = writedata[WIDTH-1:0];
  assign unused_wd_s = ^writedata;
  assign pulse_wr_s  = wr_s && (address == ADDR_PULSE) && (wd_s != ZERO_W);

  pio_in_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_in_sync (
    .clk      (clk),
    .reset    (reset),
    .in_port  (in_port),
    .sync_in  (sync_in_s),
    .edge_evt (edge_evt_s)
  );

  // Output data register: plain load, atomic set and atomic clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_r <= RST_DATA;
    end else if (wr_s) begin
      case (address)
        ADDR_DATA:   data_out_r <= wd_s;
        ADDR_OUTSET: data_out_r <= data_out_r | wd_s;
        ADDR_OUTCLR: data_out_r <= data_out_r & ~wd_s;
        default:     data_out_r <= data_out_r;
      endcase
    end else begin
      data_out_r <= data_out_r;
    end
  end

  // Interrupt mask register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask_r <= ZERO_W;
    end else if (wr_s && (address == ADDR_IRQMASK)) begin
      irq_mask_r <= wd_s;
    end else begin
      irq_mask_r <= irq_mask_r;
    end
  end

  // Sticky edge capture; a new event outranks a same-cycle write-1-to-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cap_r <= ZERO_W;
    end else if (wr_s && (address == ADDR_EDGECAP)) begin
      edge_cap_r <= (edge_cap_r & ~wd_s) | edge_evt_s;
    end else begin
      edge_cap_r <= edge_cap_r | edge_evt_s;
    end
  end

  // Pulse engine: one shared down-counter, new pulses merge and restart it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_bits_r <= ZERO_W;
      pulse_cnt_r  <= CNT_ZERO;
    end else if (pulse_wr_s) begin
      pulse_bits_r <= pulse_bits_r | wd_s;
      pulse_cnt_r  <= CNT_LOAD;
    end else if (pulse_cnt_r != CNT_ZERO) begin
      pulse_cnt_r  <= pulse_cnt_r - CNT_ONE;
      pulse_bits_r <= (pulse_cnt_r == CNT_ONE) ? ZERO_W : pulse_bits_r;
    end else begin
      pulse_bits_r <= pulse_bits_r;
      pulse_cnt_r  <= pulse_cnt_r;
    end
  end

  // Zero-wait-state read mux, zero-extended above WIDTH
  always_comb begin
    readdata = 32'h0000_0000;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = data_out_r;
      ADDR_INPUT:   readdata[WIDTH-1:0] = sync_in_s;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask_r;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap_r;
      ADDR_RSVD:    readdata = 32'h0000_0000;
      default:      readdata = 32'h0000_0000;
    endcase
  end

  assign out_port = data_out_r | pulse_bits_r;
  assign irq      = |(edge_cap_r & irq_mask_r);

endmodule

// File: tb/tb_avalon_pio_ex.sv
// Scoreboard bench for avalon_pio_ex: stimulus pushes expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_avalon_pio_ex;

  typedef struct {
    string       name;
    int          sel;   // 0 out_port, 1 readdata, 2 irq, 3 readdata W1, 4 readdata W32
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;

  logic [15:0] in_port = 16'h0;
  logic [15:0] out_port;
  logic [31:0] readdata;
  logic        irq;

  logic        in_w1 = 1'b0;
  logic        out_w1;
  logic [31:0] rd_w1;
  logic        irq_w1;

  logic [31:0] in_w32 = 32'h0;
  logic [31:0] out_w32;
  logic [31:0] rd_w32;
  logic        irq_w32;

  always #5 clk = ~clk;

  avalon_pio_ex #(.WIDTH(16), .RESET_VALUE(32'h0000_00A5), .PULSE_LEN(4),
                  .EDGE_TYPE(0), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .irq(irq));

  avalon_pio_ex #(.WIDTH(1)) dut_w1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_w1),
    .in_port(in_w1), .out_port(out_w1), .irq(irq_w1));

  avalon_pio_ex #(.WIDTH(32)) dut_w32 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_w32),
    .in_port(in_w32), .out_port(out_w32), .irq(irq_w32));

  // Monitor: compare every queued expectation at the falling edge
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb_q.pop_front();
      case (e.sel)
        0:       act = {16'h0, out_port};
        1:       act = readdata;
        2:       act = {31'h0, irq};
        3:       act = rd_w1;
        default: act = rd_w32;
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_v(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
  endtask

  // Check out_port for n consecutive cycles, one per clock edge
  task automatic expect_out_run(input string name, input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (i != 0) tick();
      expect_v(name, 0, {16'h0, v});
      settle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    settle();

    // Reset state
    rd(3'd0);
    expect_v("reset_out", 0, 32'h0000_00A5);
    expect_v("reset_rd0", 1, 32'h0000_00A5);
    expect_v("reset_irq", 2, 32'h0);
    settle();

    // DATA / OUTSET / OUTCLR
    wr(3'd0, 32'h0000_1234); expect_v("data_out", 0, 32'h1234); settle();
    wr(3'd4, 32'h0000_00C0); expect_v("outset",   0, 32'h12F4); settle();
    wr(3'd5, 32'h0000_0204); expect_v("outclr",   0, 32'h10F0); settle();
    rd(3'd0); expect_v("rd_data", 1, 32'h0000_10F0); settle();
    rd(3'd4); expect_v("rd_outset_wo", 1, 32'h0); settle();
    rd(3'd1); expect_v("rd_input", 1, 32'h0); settle();

    // Single pulse: four cycles high then low
    wr(3'd6, 32'h0000_0001);
    expect_out_run("pulse1_hi", 16'h10F1, 4);
    tick(); expect_v("pulse1_lo", 0, 32'h10F0); settle();

    // Zero pulse write is ignored
    wr(3'd6, 32'h0000_0000);
    expect_out_run("pulse0", 16'h10F0, 2);

    // Retrigger: second write merges bits and restarts the count
    wr(3'd6, 32'h0000_0001);
    expect_out_run("retrig_a", 16'h10F1, 2);
    wr(3'd6, 32'h0000_0002);
    expect_out_run("retrig_b", 16'h10F3, 4);
    tick(); expect_v("retrig_lo", 0, 32'h10F0); settle();

    // Pulse on a bit already set in data_out stays high throughout
    wr(3'd6, 32'h0000_0010);
    expect_out_run("pulse_held", 16'h10F0, 5);

    // Reset mid-pulse aborts immediately, before any further clock edge
    wr(3'd6, 32'h0000_0001);
    expect_v("pre_reset_pulse", 0, 32'h10F1); settle();
    tick();
    reset = 1'b1;
    rd(3'd0);
    expect_v("midreset_out", 0, 32'h00A5);
    expect_v("midreset_rd0", 1, 32'h0000_00A5);
    expect_v("midreset_irq", 2, 32'h0);
    settle();
    reset = 1'b0;
    tick();

    // Rising edge on bit 3: captured after three edges
    settle();
    in_port[3] = 1'b1;
    tick(); tick();
    rd(3'd3); expect_v("edge_not_yet", 1, 32'h0);
    settle();
    rd(3'd1); expect_v("rd_input_sync", 1, 32'h0000_0008); settle();
    tick();
    rd(3'd3);
    expect_v("edge_cap3", 1, 32'h0000_0008);
    expect_v("edge_irq_masked", 2, 32'h0);
    settle();
    wr(3'd2, 32'h0000_0008); expect_v("irq_on", 2, 32'h1); settle();
    rd(3'd2); expect_v("rd_irqmask", 1, 32'h0000_0008); settle();
    wr(3'd3, 32'h0000_0008);
    rd(3'd3);
    expect_v("irq_off", 2, 32'h0);
    expect_v("edge_cleared", 1, 32'h0);
    settle();

    // Edge on bit 5 coincides with W1C of the same bit: set wins
    in_port[5] = 1'b1;
    tick(); tick();
    wr(3'd3, 32'h0000_0020);
    rd(3'd3); expect_v("set_wins", 1, 32'h0000_0020); settle();

    // Falling edge ignored in rising mode
    in_port[3] = 1'b0;
    tick(); tick(); tick(); tick();
    rd(3'd3); expect_v("fall_ignored", 1, 32'h0000_0020); settle();
    wr(3'd3, 32'h0000_0020);
    rd(3'd3); expect_v("w1c_plain", 1, 32'h0); settle();

    // Width builds
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0);
    expect_v("w16_rd", 1, 32'h0000_FFFF);
    expect_v("w1_rd",  3, 32'h0000_0001);
    expect_v("w32_rd", 4, 32'hFFFF_FFFF);
    settle();
    rd(3'd7);
    expect_v("rsvd_w16", 1, 32'h0);
    expect_v("rsvd_w1",  3, 32'h0);
    expect_v("rsvd_w32", 4, 32'h0);
    settle();
    wr(3'd7, 32'h0000_0000);
    rd(3'd0); expect_v("rsvd_write_ignored", 1, 32'h0000_FFFF); settle();

    settle();
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_pio_ex.md
Name: avalon_pio_ex

Overview:
- Parametrised Avalon-MM general-purpose I/O slave; successor to the fixed 16-bit output-only PIO.
- Adds configurable width, atomic set/clear of output bits, and self-clearing timed pulse outputs.
- Adds a synchronised input port with edge capture and a maskable interrupt.
- Sits on the Nios/HPS lightweight bridge and drives camera-pipeline control strobes such as start and frame-grab.

Parameters:
- WIDTH, 16, I/O bit count; legal range 1..32.
- RESET_VALUE, 0, data_out value after reset; only the low WIDTH bits are used.
- PULSE_LEN, 4, cycles a PULSE-written bit stays high; must be >= 1.
- EDGE_TYPE, 0, capture mode: 0 = rising, 1 = falling, 2 = any edge.
- SYNC_STAGES, 2, flops in the in_port synchroniser; must be >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH are ignored.
- readdata  out  32  read data; combinational, zero wait states, zero-extended above WIDTH.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  equals data_out | pulse_bits.
- irq  out  1  equals |(edge_cap & irq_mask).

Behaviour:
- Reset (async, active-high):
  - data_out = RESET_VALUE; irq_mask = 0; edge_cap = 0; pulse_bits = 0; pulse_cnt = 0; synchroniser flops = 0.
  - Resulting outputs: out_port = RESET_VALUE, irq = 0.
  - Reset mid-pulse aborts the pulse immediately.
- Write strobe: wr = chipselect & ~write_n. Register updates happen at the clock edge where wr is high; the new values are visible on out_port and readdata in the next cycle.
- Address map:
  - 0 DATA (rw): write loads data_out; read returns data_out.
  - 1 INPUT (ro): read returns sync_in (synchronised in_port).
  - 2 IRQMASK (rw).
  - 3 EDGECAP: read returns edge_cap; write-1-to-clear.
  - 4 OUTSET (wo): data_out |= wd.
  - 5 OUTCLR (wo): data_out &= ~wd.
  - 6 PULSE (wo).
  - 7 reserved.
  - Write-only and reserved addresses read 0; writes to INPUT and reserved addresses are ignored.
- Input path:
  - in_port passes through SYNC_STAGES flops to give sync_in; one further flop gives sync_d.
  - Edge detect per bit: rising = sync_in & ~sync_d; falling = ~sync_in & sync_d.
  - A change on in_port sets edge_cap after SYNC_STAGES+1 clock edges.
- Edge capture:
  - Each edge_cap bit is sticky.
  - If a new edge and a W1C clear hit the same bit in the same cycle, set wins and the bit stays 1.
- Pulse engine:
  - One shared counter.
  - A PULSE write with wd != 0 does pulse_bits |= wd and pulse_cnt = PULSE_LEN.
  - While pulse_cnt != 0, pulse_cnt decrements each cycle. When it steps 1 -> 0, pulse_bits clears.
  - A new PULSE write during an active pulse ORs in the new bits and restarts the count; all active bits then extend together.
  - A PULSE write with wd = 0 is ignored.
  - A bit already high in data_out stays high on out_port throughout.
- Counter width: $clog2(PULSE_LEN+1). No wrap-around; the counter saturates at 0.
- irq is combinational from registers, with no added latency; it deasserts the cycle after the last masked bit is cleared.

Decomposition:
- Package avalon_pio_ex_pkg holds:
  - address constants ADDR_DATA..ADDR_PULSE (3-bit);
  - edge-type constants EDGE_RISE, EDGE_FALL, EDGE_ANY.
- Sub-module pio_in_sync (WIDTH, SYNC_STAGES, EDGE_TYPE) contains the synchroniser, the sync_d flop and the edge-detect logic. It outputs sync_in[WIDTH] and edge_evt[WIDTH].
- Register file, pulse engine and read mux live in the top module.

Test Plan:
- Reset check: RESET_VALUE=16'h00A5, assert reset mid-run -> out_port=16'h00A5, readdata@0=32'h000000A5, irq=0.
- Write DATA=16'h1234, then OUTSET 16'h00C0, then OUTCLR 16'h0204 -> out_port sequence 1234, 12F4, 10F0; each value appears one cycle after its write.
- PULSE_LEN=4: write PULSE=16'h0001 -> out_port[0] high for exactly 4 cycles, then low.
  - Rewrite PULSE=16'h0002 at cycle 2 -> both bits high through cycle 6, then low.
- EDGE_TYPE=0, SYNC_STAGES=2: drive in_port[3] 0->1 -> edge_cap=16'h0008 after 3 edges, irq=0.
  - Then IRQMASK=16'h0008 -> irq=1.
  - Then write EDGECAP=16'h0008 -> irq=0 the next cycle.
- Simultaneous event: rising edge on bit 5 arrives in the same cycle as a W1C write of 16'h0020 -> edge_cap[5] stays 1.
- WIDTH=1 and WIDTH=32 builds: DATA write 32'hFFFFFFFF -> readdata = 32'h00000001 and 32'hFFFFFFFF respectively; reads of address 7 return 0.
